// File: rtl/trace_recorder.sv
// Change-only signal recorder: captures {timestamp, value} records into on-chip memory,
// then drains them in write order over a valid/ready stream with a one-record prefetch.
module trace_recorder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 9,
  parameter int TS_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arm,
  input  logic                           stop,
  input  logic                           sample_en,
  input  logic [DATA_WIDTH-1:0]          sample_data,
  output logic                           busy,
  output logic                           full,
  output logic [DEPTH_LOG2:0]            count,
  output logic                           done,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [TS_WIDTH+DATA_WIDTH-1:0] rd_data,
  output logic                           rd_last
);
  localparam int DEPTH = 2**DEPTH_LOG2;
  localparam int RW    = TS_WIDTH + DATA_WIDTH;
  localparam int CW    = DEPTH_LOG2 + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [TS_WIDTH-1:0] TS_MAX = '1;

  logic [1:0]            state;
  logic [TS_WIDTH-1:0]   ts;
  logic                  first;
  logic [DATA_WIDTH-1:0] last_wr;
  logic [CW-1:0]         rd_ptr;
  logic                  s1_vld, s1_last;
  logic [RW-1:0]         mem [DEPTH];
  logic [RW-1:0]         mem_q;

  logic rec_wr, out_free, rd_issue, drain_end;

  always_comb begin
    rec_wr    = (state == S_REC) && sample_en && (first || (sample_data != last_wr));
    out_free  = !rd_valid || rd_ready;
    // Refill the read stage when it is empty or its record moves to the output this cycle.
    rd_issue  = (state == S_DRAIN) && (rd_ptr != count) && (!s1_vld || out_free);
    drain_end = (count == '0) || (rd_valid && rd_ready && rd_last);
    busy      = (state != S_IDLE);
  end

  // Plain memory without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rec_wr)   mem[count[DEPTH_LOG2-1:0]] <= {ts, sample_data};
    if (rd_issue) mem_q <= mem[rd_ptr[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ts       <= '0;
      first    <= 1'b0;
      last_wr  <= '0;
      count    <= '0;
      full     <= 1'b0;
      done     <= 1'b0;
      rd_ptr   <= '0;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (arm) begin
          state  <= S_REC;
          count  <= '0;
          full   <= 1'b0;
          ts     <= '0;
          first  <= 1'b1;
          rd_ptr <= '0;
        end
        S_REC: begin
          if (ts != TS_MAX) ts <= ts + TS_WIDTH'(1);
          if (rec_wr) begin
            count   <= count + CW'(1);
            first   <= 1'b0;
            last_wr <= sample_data;
          end
          if (rec_wr && (count == CW'(DEPTH - 1))) full <= 1'b1;
          if (stop || (rec_wr && (count == CW'(DEPTH - 1)))) state <= S_DRAIN;
        end
        S_DRAIN: if (drain_end) begin
          state <= S_IDLE;
          done  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase

      if (rd_issue) begin
        rd_ptr  <= rd_ptr + CW'(1);
        s1_last <= (rd_ptr == count - CW'(1));
        s1_vld  <= 1'b1;
      end else if (s1_vld && out_free) begin
        s1_vld <= 1'b0;
      end

      if (out_free) begin
        if (s1_vld) begin
          rd_valid <= 1'b1;
          rd_data  <= mem_q;
          rd_last  <= s1_last;
        end else begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_trace_recorder.sv
// Randomised and directed captures scored against a queue-based record model.
module tb_trace_recorder;
  localparam int DW = 8;
  localparam int DL = 2;
  localparam int TW = 4;
  localparam int DEPTH = 2**DL;
  localparam int TSMAX = 2**TW - 1;

  logic          clk = 0;
  logic          rst = 1;
  logic          arm = 0, stop = 0, sample_en = 0, rd_ready = 0;
  logic [DW-1:0] sample_data = '0;
  logic          busy, full, done, rd_valid, rd_last;
  logic [DL:0]   count;
  logic [TW+DW-1:0] rd_data;

  trace_recorder #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .TS_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .sample_en(sample_en),
    .sample_data(sample_data), .busy(busy), .full(full), .count(count), .done(done),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last));

  always #5 clk = ~clk;

  typedef struct { logic [TW+DW-1:0] data; logic last; } rec_t;
  rec_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0;
  int rdy_mode = 0;   // 0 always ready, 1 random, 2 fixed pattern, 3 never
  int pi = 0;
  logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic          st_en  [64];
  logic [DW-1:0] st_dat [64];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: rd_ready = 1'b1;
      1: rd_ready = 1'($urandom);
      2: begin rd_ready = pat[pi % 6]; pi++; end
      default: rd_ready = 1'b0;
    endcase
  end

  always @(negedge clk) if (done) done_cnt++;

  // Monitor: compares each transferred record with the head of the expected queue.
  logic prev_stall = 0, prev_xfer = 0, prev_last = 0;
  logic [TW+DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0; prev_xfer = 0;
    end else begin
      if (rd_valid) begin
        if (prev_stall) begin
          check("stall_data", rd_data, prev_data);
          check("stall_last", rd_last, prev_last);
        end
        if (rd_ready) begin
          n_chk++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rec_unexpected: got %0h expected none", rd_data);
          end else begin
            rec_t e;
            e = exp_q.pop_front();
            check("rec_data", rd_data, e.data);
            check("rec_last", rd_last, e.last);
          end
        end
      end else begin
        if (prev_stall) check("stall_valid", rd_valid, 1);
        if (rdy_mode == 0 && prev_xfer && exp_q.size() > 0) check("throughput", rd_valid, 1);
      end
      prev_stall = rd_valid && !rd_ready;
      prev_xfer  = rd_valid && rd_ready;
      prev_data  = rd_data;
      prev_last  = rd_last;
    end
  end

  // Drives one capture from st_en/st_dat; stop is raised on the final stimulus cycle.
  // With abort set, reset is asserted while a record is pending instead of draining.
  task automatic capture(input string tag, input int ncyc, input bit abort);
    rec_t recs[$];
    logic [DW-1:0] lastw = '0;
    bit first = 1, ended = 0;
    int cnt = 0, waited = 0;
    done_cnt = 0;
    pi = 0;
    @(posedge clk); #1 arm = 1;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk); #1;
      arm = 0;
      sample_en   = st_en[k];
      sample_data = st_dat[k];
      stop        = (k == ncyc - 1);
      if (!ended) begin
        if (st_en[k] && (first || st_dat[k] != lastw)) begin
          rec_t r;
          r.data = {TW'((k > TSMAX) ? TSMAX : k), st_dat[k]};
          r.last = 0;
          recs.push_back(r);
          cnt++; first = 0; lastw = st_dat[k];
        end
        if (cnt == DEPTH || k == ncyc - 1) begin
          ended = 1;
          if (recs.size() > 0) recs[recs.size()-1].last = 1;
          foreach (recs[i]) exp_q.push_back(recs[i]);
        end
      end
    end
    @(posedge clk); #1 sample_en = 0; stop = 0;
    if (abort) begin
      while (!rd_valid && waited < 50) begin @(negedge clk); waited++; end
      check({tag, "_valid_before_rst"}, rd_valid, 1);
      rst = 1; #1;
      check({tag, "_rst_valid"}, rd_valid, 0);
      check({tag, "_rst_busy"}, busy, 0);
      check({tag, "_rst_count"}, count, 0);
      exp_q.delete();
      @(posedge clk); #1 rst = 0;
      done_cnt = 0;
      return;
    end
    while (done_cnt == 0 && waited < 200) begin @(negedge clk); waited++; end
    repeat (3) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_count"}, count, cnt);
    check({tag, "_full"}, full, (cnt == DEPTH));
    check({tag, "_busy"}, busy, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic load_case1();
    logic [DW-1:0] d [6] = '{8'd5, 8'd5, 8'd7, 8'd7, 8'd7, 8'd9};
    for (int i = 0; i < 6; i++) begin st_en[i] = 1; st_dat[i] = d[i]; end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    check("rst_done", done, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_data", rd_data, 0);
    rst = 0;

    rdy_mode = 0; load_case1(); capture("c1", 6, 0);
    rdy_mode = 2; load_case1(); capture("c2", 6, 0);

    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin st_en[i] = 1; st_dat[i] = DW'(i + 1); end
    capture("c3_full", 6, 0);

    for (int i = 0; i < 5; i++) begin st_en[i] = 0; st_dat[i] = DW'(i); end
    capture("c4_empty", 5, 0);

    for (int i = 0; i < 21; i++) begin st_en[i] = 1; st_dat[i] = (i == 20) ? 8'd4 : 8'd3; end
    capture("c5_tssat", 21, 0);

    rdy_mode = 3; load_case1(); capture("c6_abort", 6, 1);
    rdy_mode = 0; load_case1(); capture("c6_rerun", 6, 0);

    for (int t = 0; t < 8; t++) begin
      int n;
      n = $urandom_range(1, 30);
      rdy_mode = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        st_en[i]  = 1'($urandom);
        st_dat[i] = DW'($urandom_range(0, 3));
      end
      capture("rnd", n, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
